// File: rtl/thread_scheduler.sv
// thread_scheduler: per-core control FSM that walks one block of threads through
// FETCH -> DECODE -> REQUEST -> (WAIT) -> EXECUTE -> UPDATE, owns the shared PC
// of converged lanes and broadcasts the current stage to the datapath.
// Optional build macro: SCHED_PERF_CNT_EN adds perf_cycles / perf_instrs counters.
module thread_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8,
  parameter int TC_WIDTH          = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [TC_WIDTH-1:0]          thread_count,
  input  logic                         fetch_ready,
  input  logic                         decoded_mem,
  input  logic                         decoded_ret,
  input  logic [THREADS_PER_BLOCK-1:0] lsu_busy,
  input  logic [PC_WIDTH-1:0]          next_pc,
  output logic [2:0]                   core_state,
  output logic                         fetch_req,
  output logic [PC_WIDTH-1:0]          current_pc,
  output logic [THREADS_PER_BLOCK-1:0] active_mask,
  output logic                         done
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_cycles,
  output logic [31:0]                  perf_instrs
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_REQUEST = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_EXECUTE = 3'd5;
  localparam logic [2:0] S_UPDATE  = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [TC_WIDTH-1:0] TC_MAX = TC_WIDTH'(THREADS_PER_BLOCK);

  // Lane i is active iff i is below the (already clamped) thread count.
  function automatic logic [THREADS_PER_BLOCK-1:0] lanes_below(input logic [TC_WIDTH-1:0] cnt);
    logic [THREADS_PER_BLOCK-1:0] m;
    m = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      m[i] = (TC_WIDTH'(i) < cnt);
    end
    return m;
  endfunction

  logic [2:0]                   state_q, state_d;
  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic [THREADS_PER_BLOCK-1:0] mask_q, mask_d;
  logic                         fetch_req_q, fetch_req_d;
  logic                         done_q, done_d;
  logic                         start_ok_s;
  logic [TC_WIDTH-1:0]          count_clamped_s;

  // Clamp the requested thread count to the number of physical lanes.
  always_comb begin
    if (thread_count > TC_MAX) begin
      count_clamped_s = TC_MAX;
    end else begin
      count_clamped_s = thread_count;
    end
  end

  // Next-state, shared PC and lane mask; outputs are derived from the next state
  // so that every broadcast signal is registered and aligned with core_state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mask_d     = mask_q;
    start_ok_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // A launch from DONE with zero threads lands straight back in DONE.
          start_ok_s = 1'b1;
          mask_d     = lanes_below(count_clamped_s);
          pc_d       = '0;
          if (count_clamped_s != '0) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        if (fetch_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        state_d = S_REQUEST;
      end
      S_REQUEST: begin
        if (decoded_mem) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_WAIT: begin
        // Only lanes that belong to this block can hold the core in WAIT.
        if ((lsu_busy & mask_q) == '0) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_EXECUTE: begin
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (decoded_ret) begin
          state_d = S_DONE;
        end else begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    fetch_req_d = (state_d == S_FETCH);
    done_d      = (state_d == S_DONE);
  end

  // Control state and registered outputs; reset discards any in-flight work.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      mask_q      <= '0;
      fetch_req_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mask_q      <= mask_d;
      fetch_req_q <= fetch_req_d;
      done_q      <= done_d;
    end
  end

  assign core_state  = state_q;
  assign current_pc  = pc_q;
  assign active_mask = mask_q;
  assign fetch_req   = fetch_req_q;
  assign done        = done_q;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ins_q, ins_d;

  // Saturating busy-cycle and retired-instruction counters, cleared per launch.
  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (start_ok_s) begin
      cyc_d = 32'd0;
      ins_d = 32'd0;
    end else begin
      if ((state_q != S_IDLE) && (state_q != S_DONE) && (cyc_q != 32'hFFFF_FFFF)) begin
        cyc_d = cyc_q + 32'd1;
      end else begin
        cyc_d = cyc_q;
      end
      if ((state_q == S_UPDATE) && (ins_q != 32'hFFFF_FFFF)) begin
        ins_d = ins_q + 32'd1;
      end else begin
        ins_d = ins_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q <= 32'd0;
      ins_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_instrs = ins_q;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler (THREADS_PER_BLOCK=4, PC_WIDTH=8).
// Directed vector table, hand-written multi-cycle sequences and a randomized
// run compared every cycle against a behavioural model of the scheduler rules.
module tb_thread_scheduler;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] thread_count;
  logic       fetch_ready;
  logic       decoded_mem;
  logic       decoded_ret;
  logic [3:0] lsu_busy;
  logic [7:0] next_pc;
  logic [2:0] core_state;
  logic       fetch_req;
  logic [7:0] current_pc;
  logic [3:0] active_mask;
  logic       done;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_instrs;
`endif

  thread_scheduler #(.THREADS_PER_BLOCK(4), .PC_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .thread_count(thread_count),
    .fetch_ready(fetch_ready), .decoded_mem(decoded_mem), .decoded_ret(decoded_ret),
    .lsu_busy(lsu_busy), .next_pc(next_pc), .core_state(core_state),
    .fetch_req(fetch_req), .current_pc(current_pc), .active_mask(active_mask),
    .done(done)
`ifdef SCHED_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_instrs(perf_instrs)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: stage number, PC, lane mask, counters.
  int     m_state = 0;
  int     m_pc    = 0;
  int     m_mask  = 0;
  longint m_cyc   = 0;
  longint m_ins   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stage rules: idle/done accept a launch, fetch waits for the fetcher, memory
  // ops wait for active lanes, UPDATE either retires the block or moves the PC.
  task automatic model_update();
    int old;
    int cnt;
    old = m_state;
    if (reset) begin
      m_state = 0; m_pc = 0; m_mask = 0; m_cyc = 0; m_ins = 0;
    end else if ((old == 0 || old == 7) && start) begin
      cnt     = (int'(thread_count) > 4) ? 4 : int'(thread_count);
      m_mask  = (1 << cnt) - 1;
      m_pc    = 0;
      m_state = (cnt > 0) ? 1 : 7;
      m_cyc   = 0;
      m_ins   = 0;
    end else begin
      if (old != 0 && old != 7 && m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (old == 6 && m_ins < 64'hFFFF_FFFF) m_ins++;
      case (old)
        1: if (fetch_ready) m_state = 2;
        2: m_state = 3;
        3: m_state = decoded_mem ? 4 : 5;
        4: if ((int'(lsu_busy) & m_mask) == 0) m_state = 5;
        5: m_state = 6;
        6: begin
          if (decoded_ret) m_state = 7;
          else begin m_pc = int'(next_pc); m_state = 1; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".state"}, 32'(core_state), 32'(m_state));
    check({tag, ".pc"}, 32'(current_pc), 32'(m_pc));
    check({tag, ".mask"}, 32'(active_mask), 32'(m_mask));
    check({tag, ".done"}, 32'(done), 32'(m_state == 7));
    check({tag, ".fetch_req"}, 32'(fetch_req), 32'(m_state == 1));
`ifdef SCHED_PERF_CNT_EN
    check({tag, ".perf_cycles"}, perf_cycles, 32'(m_cyc));
    check({tag, ".perf_instrs"}, perf_instrs, 32'(m_ins));
`endif
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; thread_count = 3'd0; fetch_ready = 1'b0;
    decoded_mem = 1'b0; decoded_ret = 1'b0; lsu_busy = 4'd0; next_pc = 8'd0;
  endtask

  typedef struct {
    logic       rst, st;
    logic [2:0] tc;
    logic       fr, mem, ret;
    logic [3:0] busy;
    logic [7:0] npc;
    logic [2:0] e_state;
    logic [7:0] e_pc;
    logic [3:0] e_mask;
    logic       e_done, e_freq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, st, input logic [2:0] tc, input logic fr, mem, ret,
                     input logic [3:0] busy, input logic [7:0] npc, input logic [2:0] es,
                     input logic [7:0] epc, input logic [3:0] em, input logic ed, ef);
    vec_t v;
    v = '{rst, st, tc, fr, mem, ret, busy, npc, es, epc, em, ed, ef};
    vecs.push_back(v);
  endtask

  initial begin
    int n_req, cyc, n_upd;
    logic was_upd;

    idle_inputs();

    //   rst st tc fr mem ret busy  npc     state pc     mask  done freq
    add(1, 0, 0, 0, 0, 0, 4'h0, 8'h00,  0, 8'h00, 4'h0, 0, 0); // reset
    add(0, 1, 4, 0, 0, 0, 4'h0, 8'h00,  1, 8'h00, 4'hF, 0, 1); // launch 4 lanes
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  2, 8'h00, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  3, 8'h00, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  5, 8'h00, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  6, 8'h00, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h01,  1, 8'h01, 4'hF, 0, 1); // pc -> 1
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  2, 8'h01, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  3, 8'h01, 4'hF, 0, 0);
    add(0, 0, 0, 1, 1, 0, 4'h0, 8'h00,  4, 8'h01, 4'hF, 0, 0); // memory op: WAIT #1
    add(0, 0, 0, 1, 1, 0, 4'h2, 8'h00,  4, 8'h01, 4'hF, 0, 0); // lane1 busy: WAIT #2
    add(0, 0, 0, 1, 1, 0, 4'h2, 8'h00,  4, 8'h01, 4'hF, 0, 0); // lane1 busy: WAIT #3
    add(0, 0, 0, 1, 1, 0, 4'h0, 8'h00,  5, 8'h01, 4'hF, 0, 0); // clear -> EXECUTE
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  6, 8'h01, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h02,  1, 8'h02, 4'hF, 0, 1); // pc -> 2
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  2, 8'h02, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  3, 8'h02, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  5, 8'h02, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  6, 8'h02, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 1, 4'h0, 8'h09,  7, 8'h02, 4'hF, 1, 0); // RET: pc kept
    add(0, 1, 0, 0, 0, 0, 4'h0, 8'h00,  7, 8'h00, 4'h0, 1, 0); // start, 0 threads
    add(0, 0, 0, 0, 0, 0, 4'h0, 8'h00,  7, 8'h00, 4'h0, 1, 0);
    add(0, 1, 2, 0, 0, 0, 4'h0, 8'h00,  1, 8'h00, 4'h3, 0, 1); // relaunch 2 lanes
    add(0, 0, 0, 0, 0, 0, 4'h0, 8'h00,  1, 8'h00, 4'h3, 0, 1); // fetch stall
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  2, 8'h00, 4'h3, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  3, 8'h00, 4'h3, 0, 0);
    add(0, 0, 0, 1, 1, 0, 4'h0, 8'h00,  4, 8'h00, 4'h3, 0, 0);
    add(0, 0, 0, 1, 1, 0, 4'hC, 8'h00,  5, 8'h00, 4'h3, 0, 0); // inactive lanes busy
    add(0, 0, 0, 1, 0, 0, 4'hC, 8'h00,  6, 8'h00, 4'h3, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'hFF,  1, 8'hFF, 4'h3, 0, 1);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  2, 8'hFF, 4'h3, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  3, 8'hFF, 4'h3, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  5, 8'hFF, 4'h3, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  6, 8'hFF, 4'h3, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h10,  1, 8'h10, 4'h3, 0, 1);
    add(1, 0, 0, 1, 0, 0, 4'h0, 8'h00,  0, 8'h00, 4'h0, 0, 0); // reset mid-block
    add(0, 1, 7, 0, 0, 0, 4'h0, 8'h00,  1, 8'h00, 4'hF, 0, 1); // count clamped to 4
    add(0, 1, 1, 0, 0, 0, 4'h0, 8'h00,  1, 8'h00, 4'hF, 0, 1); // start ignored
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  2, 8'h00, 4'hF, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 8'h00,  3, 8'h00, 4'hF, 0, 0);
    add(0, 0, 0, 1, 1, 0, 4'h0, 8'h00,  4, 8'h00, 4'hF, 0, 0);
    add(0, 0, 0, 1, 1, 0, 4'hF, 8'h00,  4, 8'h00, 4'hF, 0, 0);
    add(1, 0, 0, 1, 1, 0, 4'hF, 8'h00,  0, 8'h00, 4'h0, 0, 0); // reset in WAIT
    add(0, 1, 3, 0, 0, 0, 4'h0, 8'h00,  1, 8'h00, 4'h7, 0, 1);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; start = vecs[i].st; thread_count = vecs[i].tc;
      fetch_ready = vecs[i].fr; decoded_mem = vecs[i].mem; decoded_ret = vecs[i].ret;
      lsu_busy = vecs[i].busy; next_pc = vecs[i].npc;
      step();
      check($sformatf("vec%0d.state", i), 32'(core_state), 32'(vecs[i].e_state));
      check($sformatf("vec%0d.pc", i), 32'(current_pc), 32'(vecs[i].e_pc));
      check($sformatf("vec%0d.mask", i), 32'(active_mask), 32'(vecs[i].e_mask));
      check($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d.fetch_req", i), 32'(fetch_req), 32'(vecs[i].e_freq));
    end

    // Fetch stall: six low fetch_ready samples keep FETCH for seven cycles.
    idle_inputs(); reset = 1'b1; step();
    reset = 1'b0; start = 1'b1; thread_count = 3'd3; step();
    start = 1'b0; fetch_ready = 1'b0; n_req = 0;
    for (int i = 0; i < 6; i++) begin
      if (fetch_req === 1'b1) n_req++;
      step();
      check("stall.state", 32'(core_state), 32'd1);
    end
    fetch_ready = 1'b1;
    if (fetch_req === 1'b1) n_req++;
    step();
    check("stall.req_cycles", 32'(n_req), 32'd7);
    check("stall.req_drop", 32'(fetch_req), 32'd0);
    check("stall.decode", 32'(core_state), 32'd2);

    // Loop latency: FETCH entry to next FETCH entry for a plain instruction.
    next_pc = 8'd1; cyc = 0;
    while (core_state != 3'd1 && cyc < 20) begin step(); cyc++; end
    check("lat.pc1", 32'(current_pc), 32'd1);
    next_pc = 8'd2; cyc = 0;
    do begin step(); cyc++; end while (core_state != 3'd1 && cyc < 20);
    check("lat.cycles", 32'(cyc), 32'd5);
    check("lat.pc2", 32'(current_pc), 32'd2);

`ifdef SCHED_PERF_CNT_EN
    // Three plain instructions, RET on the third, fetcher always ready.
    idle_inputs(); reset = 1'b1; step();
    reset = 1'b0; start = 1'b1; thread_count = 3'd4; step();
    start = 1'b0; fetch_ready = 1'b1; n_upd = 0;
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin
      decoded_ret = (n_upd == 2);
      was_upd = (core_state == 3'd6);
      step();
      if (was_upd) n_upd++;
    end
    check("perf.done", 32'(done), 32'd1);
    check("perf.instrs", perf_instrs, 32'd3);
    check("perf.cycles", perf_cycles, 32'd15);
    decoded_ret = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("perf.instrs_hold", perf_instrs, 32'd3);
    check("perf.cycles_hold", perf_cycles, 32'd15);
`else
    n_upd = 0; was_upd = 1'b0;
`endif

    // Randomized run against the behavioural model.
    idle_inputs(); reset = 1'b1; step();
    compare_model("rnd_reset");
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      start        = ($urandom_range(0, 3) == 0);
      thread_count = 3'($urandom_range(0, 7));
      fetch_ready  = ($urandom_range(0, 2) != 0);
      decoded_mem  = 1'($urandom_range(0, 1));
      decoded_ret  = ($urandom_range(0, 4) == 0);
      lsu_busy     = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      next_pc      = 8'($urandom_range(0, 255));
      step();
      compare_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
- Per-core control FSM that sequences the thread datapath through fetch, decode, request, wait, execute and update for one block of threads.
- Broadcasts the current stage to all thread lanes and fetcher/decoder.
- Owns the shared PC for converged threads.
- Stalls on instruction fetch and on outstanding per-thread LSU requests; sits between dispatcher and thread datapath.

Parameters:
THREADS_PER_BLOCK, 4, number of thread lanes (T); power of two, 1..16
PC_WIDTH, 8, program counter width
TC_WIDTH, $clog2(THREADS_PER_BLOCK)+1, width of thread_count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  launch block; sampled only in IDLE or DONE
thread_count  in  TC_WIDTH  active threads for this block; latched on accepted start
fetch_ready  in  1  fetcher returns valid instruction this cycle
decoded_mem  in  1  current instruction is LDR/STR; valid from DECODE onward
decoded_ret  in  1  current instruction is RET; valid from DECODE onward
lsu_busy  in  THREADS_PER_BLOCK  per-lane LSU request outstanding
next_pc  in  PC_WIDTH  lane-0 computed next PC; valid in UPDATE
core_state  out  3  stage broadcast to datapath
fetch_req  out  1  request instruction at current_pc
current_pc  out  PC_WIDTH  shared PC
active_mask  out  THREADS_PER_BLOCK  bit i = 1 iff i < latched thread_count
done  out  1  block finished

Behaviour:
- Single clock domain: `clock`, rising edge. `reset` is synchronous and active-high.
- State encoding on core_state: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7. All outputs are registered.
- Reset (any cycle, including mid-block):
  - state=IDLE, current_pc=0, active_mask=0, done=0, fetch_req=0.
  - In-flight fetch/LSU results are discarded.
- IDLE:
  - start=1 -> latch thread_count, clamped to T; set active_mask; current_pc<=0.
  - Go to FETCH if count>0; if count==0 go to DONE.
- FETCH:
  - fetch_req=1 for every cycle in FETCH.
  - fetch_ready=1 -> DECODE, with fetch_req=0 the same edge. Waits unbounded otherwise.
- DECODE: exactly 1 cycle -> REQUEST.
- REQUEST: exactly 1 cycle. Lanes issue LSU requests this cycle.
  - decoded_mem=1 -> WAIT; else -> EXECUTE.
- WAIT:
  - lsu_busy is guaranteed valid from the first WAIT cycle.
  - Exit to EXECUTE when (lsu_busy & active_mask)==0.
  - Busy bits of inactive lanes are ignored. Minimum 1 cycle in WAIT.
- EXECUTE: exactly 1 cycle -> UPDATE.
- UPDATE:
  - decoded_ret=1 -> DONE; current_pc unchanged.
  - Else current_pc<=next_pc, then FETCH.
  - PC wraps modulo 2^PC_WIDTH; no error is raised.
- DONE:
  - done=1 held.
  - start=1 -> done<=0, relatch thread_count, current_pc<=0, go to FETCH; count==0 stays in DONE with done=1.
- start outside IDLE/DONE is ignored.
- Latency: non-memory instruction with fetch_ready already high = 5 cycles from FETCH entry to next FETCH entry. A memory instruction adds WAIT cycles (≥1).

Optional Feature:
Macro SCHED_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_cycles[31:0] and perf_instrs[31:0].
  - Both clear on reset and on an accepted start.
  - perf_cycles increments every cycle while state ∉ {IDLE, DONE}.
  - perf_instrs increments on each UPDATE cycle, including RET.
  - Both saturate at 32'hFFFF_FFFF and hold while in DONE.
- Undefined: ports absent; no counter logic.

Test Plan:
- Reset then start=1 with thread_count=4, fetch_ready tied 1, decoded_mem=0, decoded_ret=0, next_pc=current_pc+1 -> core_state sequence 1,2,3,5,6,1..., current_pc increments every 5 cycles, active_mask=4'b1111.
- Memory op: decoded_mem=1, lsu_busy=4'b0010 for 3 WAIT cycles then 0 -> exactly 3 WAIT cycles, then EXECUTE.
- thread_count=2, lsu_busy=4'b1100 held high -> WAIT exits after 1 cycle because busy bits are on inactive lanes; active_mask=4'b0011.
- RET on 3rd instruction -> done=1 after that UPDATE, current_pc=2, state 7. New start with thread_count=0 -> stays DONE, done=1.
- Fetch stall: fetch_ready low 6 cycles -> fetch_req high 6+1 cycles, state stays 1. Reset asserted in WAIT -> next cycle state=0, pc=0, done=0, fetch_req=0.
- With SCHED_PERF_CNT_EN: 3 non-memory instructions ending in RET, fetch_ready=1 -> perf_instrs=3, perf_cycles=15.
